// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send and
// shifts one command byte out on device-generated clock edges, open-drain style.
//
// state      | meaning
// IDLE       | ready for a byte, both lines released
// INHIBIT    | CLK pulled low for INHIBIT_CYCLES
// START      | start bit (DAT low) presented, waiting for first device clock
// DATA       | data and parity bits, changed on each falling clock
// ACK        | stop bit released, waiting for the device ACK on fall 11
// WAIT_IDLE  | ACK seen, waiting for both lines to return high
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 3000,
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 400000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic [1:0] o_err_code,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_dat_oe
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int FLT_W = $clog2(FILTER_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_START, S_DATA, S_ACK, S_WAIT_IDLE
    } state_t;

    state_t           r_state;
    logic             r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic             r_filt_clk, r_fall;
    logic [FLT_W-1:0] r_filt_cnt;
    logic [INH_W-1:0] r_inh_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic [7:0]       r_data;
    logic             r_parity;
    logic [3:0]       r_bit_cnt;
    logic             r_ready, r_busy, r_done, r_err, r_clk_oe, r_dat_oe;
    logic [1:0]       r_err_code;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_filt_clk <= 1'b1;
            r_filt_cnt <= '0;
            r_fall     <= 1'b0;
        end else begin
            r_clk_s1 <= i_ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= i_ps2_dat;
            r_dat_s2 <= r_dat_s1;
            r_fall   <= 1'b0;
            // any sample agreeing with the filtered level restarts the run
            if (r_clk_s2 == r_filt_clk) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FLT_W'(FILTER_CYCLES - 1)) begin
                r_filt_clk <= r_clk_s2;
                r_filt_cnt <= '0;
                r_fall     <= r_filt_clk;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
            r_clk_oe   <= 1'b0;
            r_dat_oe   <= 1'b0;
            r_data     <= '0;
            r_parity   <= 1'b0;
            r_bit_cnt  <= '0;
            r_inh_cnt  <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_data     <= i_data;
                        r_parity   <= ~^i_data;
                        r_err_code <= 2'b00;
                        r_bit_cnt  <= '0;
                        r_inh_cnt  <= INH_W'(INHIBIT_CYCLES - 1);
                        r_clk_oe   <= 1'b1;
                        r_ready    <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (r_inh_cnt == '0) begin
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b1;
                        r_to_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
                        r_state  <= S_START;
                    end else begin
                        r_inh_cnt <= r_inh_cnt - 1'b1;
                    end
                end
                S_START, S_DATA, S_ACK, S_WAIT_IDLE: begin
                    // timeout wins over a coincident clock fall
                    if (r_to_cnt == '0) begin
                        r_clk_oe   <= 1'b0;
                        r_dat_oe   <= 1'b0;
                        r_err      <= 1'b1;
                        r_err_code <= 2'b01;
                        r_ready    <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt - 1'b1;
                        case (r_state)
                            S_START: begin
                                if (r_fall) begin
                                    r_bit_cnt <= 4'd1;
                                    r_dat_oe  <= ~r_data[0];
                                    r_state   <= S_DATA;
                                end
                            end
                            S_DATA: begin
                                if (r_fall) begin
                                    r_bit_cnt <= r_bit_cnt + 1'b1;
                                    if (r_bit_cnt < 4'd8) begin
                                        r_dat_oe <= ~r_data[r_bit_cnt[2:0]];
                                    end else if (r_bit_cnt == 4'd8) begin
                                        r_dat_oe <= ~r_parity;
                                    end else begin
                                        r_dat_oe <= 1'b0;
                                        r_state  <= S_ACK;
                                    end
                                end
                            end
                            S_ACK: begin
                                if (r_fall) begin
                                    if (!r_dat_s2) begin
                                        r_state <= S_WAIT_IDLE;
                                    end else begin
                                        r_err      <= 1'b1;
                                        r_err_code <= 2'b10;
                                        r_ready    <= 1'b1;
                                        r_busy     <= 1'b0;
                                        r_state    <= S_IDLE;
                                    end
                                end
                            end
                            S_WAIT_IDLE: begin
                                if (r_clk_s2 && r_dat_s2) begin
                                    r_done  <= 1'b1;
                                    r_ready <= 1'b1;
                                    r_busy  <= 1'b0;
                                    r_state <= S_IDLE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: begin
                    r_clk_oe <= 1'b0;
                    r_dat_oe <= 1'b0;
                    r_ready  <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ready      = r_ready;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_err_code   = r_err_code;
    assign o_ps2_clk_oe = r_clk_oe;
    assign o_ps2_dat_oe = r_dat_oe;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device on a wired-AND bus, with frames
// checked against bit patterns computed from the command byte.
module tb_ps2_host_tx;
    localparam int INH = 300;
    localparam int FLT = 8;
    localparam int TO  = 5000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ready, busy, done, err, clk_oe, dat_oe;
    logic [1:0] code;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       line_clk, line_dat;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_starts = 0;
    logic prev_clk_oe = 1'b0;

    assign line_clk = ~clk_oe & dev_clk;
    assign line_dat = ~dat_oe & dev_dat;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .FILTER_CYCLES(FLT), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data),
        .o_ready(ready), .o_busy(busy), .o_done(done), .o_err(err), .o_err_code(code),
        .i_ps2_clk(line_clk), .i_ps2_dat(line_dat),
        .o_ps2_clk_oe(clk_oe), .o_ps2_dat_oe(dat_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (done && err) both_cnt++;
        if (clk_oe && !prev_clk_oe) inh_starts++;
        prev_clk_oe = clk_oe;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Device side: waits for the request-to-send, then clocks 11 bits, sampling DAT
    // before each rising edge; stop_fall>0 abandons the frame just after that fall.
    task automatic device(input int half, input bit ack, input bit glitch, input int stop_fall,
                          output int inh_len, output logic start_bit,
                          output logic [9:0] bits, output bit ok);
        int t;
        ok = 1'b1; bits = '0; inh_len = 0; start_bit = 1'b1; t = 0;
        while (!clk_oe && t < 1000) begin @(negedge clk); t++; end
        if (!clk_oe) begin ok = 1'b0; return; end
        while (clk_oe && inh_len < INH + 1000) begin @(negedge clk); inh_len++; end
        start_bit = line_dat;
        for (int i = 1; i <= 11; i++) begin
            if (i == 11 && ack) dev_dat = 1'b0;
            if (glitch && i > 1) begin
                repeat (half / 2) @(negedge clk);
                dev_clk = 1'b0;
                repeat (3) @(negedge clk);
                dev_clk = 1'b1;
                repeat (half - half / 2 - 3) @(negedge clk);
            end else begin
                repeat (half) @(negedge clk);
            end
            dev_clk = 1'b0;
            if (i == stop_fall) begin repeat (20) @(negedge clk); return; end
            repeat (half) @(negedge clk);
            if (i <= 10) bits[i-1] = line_dat;
            dev_clk = 1'b1;
        end
        repeat (half / 2) @(negedge clk);
        dev_dat = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL rst_pulses: got done=%b err=%b want 0 0", done, err); end
        n_cmp++; if (code !== 2'b00) begin n_bad++; $display("FAIL rst_code: got %b want 00", code); end
        n_cmp++; if (clk_oe !== 1'b0 || dat_oe !== 1'b0) begin n_bad++; $display("FAIL rst_oe: got %b%b want 00", clk_oe, dat_oe); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_release: got ready=%b busy=%b want 1 0", ready, busy); end
    endtask

    task automatic test_transfer(input logic [7:0] b, input bit ack, input bit glitch,
                                 input bit hold_valid, input int half);
        int d0, e0, s0, b0, t, ones, inh_len;
        logic exp_par, start_bit;
        logic [9:0] bits;
        bit ok;
        d0 = done_cnt; e0 = err_cnt; s0 = inh_starts; b0 = both_cnt;
        ones = 0;
        for (int i = 0; i < 8; i++) if (((b >> i) & 8'h01) != 0) ones++;
        exp_par = (ones % 2 == 0);
        @(negedge clk);
        data = b; valid = 1'b1;
        if (!hold_valid) begin @(negedge clk); valid = 1'b0; end
        device(half, ack, glitch, 0, inh_len, start_bit, bits, ok);
        t = 0;
        while (!done && !err && (done_cnt - d0) + (err_cnt - e0) == 0 && t < TO) begin
            @(negedge clk); t++;
        end
        valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL req_to_send %h: got no CLK inhibit want inhibit", b); end
        n_cmp++; if (inh_len !== INH) begin n_bad++; $display("FAIL inhibit_len %h: got %0d want %0d", b, inh_len, INH); end
        n_cmp++; if (start_bit !== 1'b0) begin n_bad++; $display("FAIL start_bit %h: got %b want 0", b, start_bit); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (bits[i] !== ((b >> i) & 8'h01) != 0) begin
                n_bad++; $display("FAIL data_bit%0d %h: got %b want %b", i, b, bits[i], ((b >> i) & 8'h01) != 0);
            end
        end
        n_cmp++; if (bits[8] !== exp_par) begin n_bad++; $display("FAIL parity %h: got %b want %b", b, bits[8], exp_par); end
        n_cmp++; if (bits[9] !== 1'b1) begin n_bad++; $display("FAIL stop_bit %h: got %b want 1", b, bits[9]); end
        if (ack) begin
            n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL done_count %h: got %0d want 1", b, done_cnt - d0); end
            n_cmp++; if (err_cnt - e0 != 0) begin n_bad++; $display("FAIL err_count %h: got %0d want 0", b, err_cnt - e0); end
            n_cmp++; if (code !== 2'b00) begin n_bad++; $display("FAIL err_code %h: got %b want 00", b, code); end
        end else begin
            n_cmp++; if (done_cnt - d0 != 0) begin n_bad++; $display("FAIL noack_done %h: got %0d want 0", b, done_cnt - d0); end
            n_cmp++; if (err_cnt - e0 != 1) begin n_bad++; $display("FAIL noack_err %h: got %0d want 1", b, err_cnt - e0); end
            n_cmp++; if (code !== 2'b10) begin n_bad++; $display("FAIL noack_code %h: got %b want 10", b, code); end
        end
        n_cmp++; if (both_cnt - b0 != 0) begin n_bad++; $display("FAIL done_err_overlap %h: got %0d want 0", b, both_cnt - b0); end
        n_cmp++; if (inh_starts - s0 != 1) begin n_bad++; $display("FAIL accept_count %h: got %0d want 1", b, inh_starts - s0); end
        n_cmp++; if (clk_oe !== 1'b0 || dat_oe !== 1'b0 || ready !== 1'b1) begin
            n_bad++; $display("FAIL end_state %h: got oe=%b%b ready=%b want oe=00 ready=1", b, clk_oe, dat_oe, ready);
        end
    endtask

    task automatic test_timeout();
        int t, c, d0;
        d0 = done_cnt;
        @(negedge clk);
        data = 8'($urandom); valid = 1'b1;
        @(negedge clk); valid = 1'b0;
        t = 0;
        while (clk_oe && t < INH + 100) begin @(negedge clk); t++; end
        c = 0;
        while (!err && c < TO + 100) begin @(negedge clk); c++; end
        n_cmp++; if (c != TO) begin n_bad++; $display("FAIL timeout_cycles: got %0d want %0d", c, TO); end
        @(negedge clk);
        n_cmp++; if (code !== 2'b01) begin n_bad++; $display("FAIL timeout_code: got %b want 01", code); end
        n_cmp++; if (ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL timeout_ready: got ready=%b busy=%b want 1 0", ready, busy); end
        n_cmp++; if (clk_oe !== 1'b0 || dat_oe !== 1'b0) begin n_bad++; $display("FAIL timeout_oe: got %b%b want 00", clk_oe, dat_oe); end
        n_cmp++; if (done_cnt != d0) begin n_bad++; $display("FAIL timeout_done: got %0d want 0", done_cnt - d0); end
    endtask

    task automatic test_reset_mid();
        int inh_len;
        logic start_bit;
        logic [9:0] bits;
        bit ok;
        @(negedge clk);
        data = 8'hA5; valid = 1'b1;
        @(negedge clk); valid = 1'b0;
        device(50, 1'b1, 1'b0, 5, inh_len, start_bit, bits, ok);
        n_cmp++; if (dat_oe !== 1'b1) begin n_bad++; $display("FAIL mid_dat_bit4: got %b want 1", dat_oe); end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (clk_oe !== 1'b0 || dat_oe !== 1'b0) begin n_bad++; $display("FAIL async_release: got %b%b want 00", clk_oe, dat_oe); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1; dev_clk = 1'b1; dev_dat = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (ready !== 1'b1 || busy !== 1'b0 || code !== 2'b00) begin
            n_bad++; $display("FAIL post_reset: got ready=%b busy=%b code=%b want 1 0 00", ready, busy, code);
        end
        repeat (30) @(negedge clk);
        test_transfer(8'hFF, 1'b1, 1'b0, 1'b0, 50);
    endtask

    task automatic test_random();
        for (int k = 0; k < 5; k++) begin
            test_transfer(8'($urandom), ($urandom % 4) != 0, 1'b0, 1'b0, int'($urandom_range(40, 70)));
            repeat (20) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_transfer(8'hED, 1'b1, 1'b0, 1'b0, 50);
        repeat (20) @(negedge clk);
        test_transfer(8'hF4, 1'b1, 1'b0, 1'b0, 60);
        repeat (20) @(negedge clk);
        test_transfer(8'h3A, 1'b0, 1'b0, 1'b0, 50);
        repeat (20) @(negedge clk);
        test_timeout();
        repeat (20) @(negedge clk);
        test_transfer(8'h55, 1'b1, 1'b1, 1'b0, 50);
        repeat (20) @(negedge clk);
        test_transfer(8'hC3, 1'b1, 1'b0, 1'b1, 45);
        repeat (20) @(negedge clk);
        test_reset_mid();
        repeat (20) @(negedge clk);
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
